uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_pkg.sv | 47 ++++
 rtl/uart_tx_mux.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and encodings for the UART transmit controller slice.
// State enum, line-source select codes and small decode helpers.
package uart_tx_pkg;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Line-source select codes driven on mux_sel.
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Line source that goes with a given state (idle shares the stop level).
  function automatic logic [1:0] mux_sel_of(input tx_state_t st);
    logic [1:0] sel_v;
    sel_v = MUX_STOP;
    case (st)
      ST_IDLE:   sel_v = MUX_STOP;
      ST_START:  sel_v = MUX_START;
      ST_DATA:   sel_v = MUX_DATA;
      ST_PARITY: sel_v = MUX_PAR;
      ST_STOP:   sel_v = MUX_STOP;
      default:   sel_v = MUX_STOP;
    endcase
    return sel_v;
  endfunction

  // A frame is on the line in every state except idle.
  function automatic logic busy_of(input tx_state_t st);
    logic busy_v;
    busy_v = 1'b1;
    if (st == ST_IDLE) begin
      busy_v = 1'b0;
    end else begin
      busy_v = 1'b1;
    end
    return busy_v;
  endfunction

endpackage

// File: rtl/uart_tx_mux.sv
// Serial line source multiplexer: picks start level, stop/idle level,
// the addressed payload bit or the parity bit according to mux_sel.
module uart_tx_mux
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic [1:0]            mux_sel,
  input  logic [DATA_WIDTH-1:0] frame,
  input  logic [CNT_W-1:0]      bit_idx,
  input  logic                  par_bit,
  output logic                  line_s
);

  // Select the line level for the chosen source; stop level is the safe fallback.
  always_comb begin
    line_s = 1'b1;
    case (mux_sel)
      MUX_START: line_s = 1'b0;
      MUX_STOP:  line_s = 1'b1;
      MUX_DATA:  line_s = frame[bit_idx];
      MUX_PAR:   line_s = par_bit;
      default:   line_s = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Frames a DATA_WIDTH payload as start bit,
// LSB-first data, optional parity bit and stop bit. The parity generator
// is external: it is loaded through par_data/par_valid on accept and its
// result comes back on par_bit. TX_OUT, mux_sel and Busy are registered
// from the next-state decode so they line up with the state of each cycle.
// DATA_WIDTH is intended for 5..9.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  par_valid,
  output logic [1:0]            mux_sel,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_ZERO = CNT_W'(0);

  tx_state_t             state_r;
  tx_state_t             state_nx_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [CNT_W-1:0]      bit_cnt_nx_s;
  logic [DATA_WIDTH-1:0] frame_r;
  logic                  par_en_r;
  logic                  accept_s;
  logic [1:0]            mux_sel_nx_s;
  logic                  line_nx_s;

  // A new frame is taken only when the line is idle or finishing a stop bit.
  always_comb begin
    accept_s = 1'b0;
    if (DATA_Valid && ((state_r == ST_IDLE) || (state_r == ST_STOP))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // The parity unit sees the raw payload; its load strobe is the accept, held off in reset.
  assign par_data  = P_DATA;
  assign par_valid = accept_s & ~RST;

  // Next-state and bit-counter decode.
  always_comb begin
    state_nx_s   = state_r;
    bit_cnt_nx_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx_s   = ST_DATA;
        bit_cnt_nx_s = BIT_ZERO;
      end
      ST_DATA: begin
        if (bit_cnt_r == BIT_LAST) begin
          if (par_en_r) begin
            state_nx_s = ST_PARITY;
          end else begin
            state_nx_s = ST_STOP;
          end
        end else begin
          state_nx_s   = ST_DATA;
          bit_cnt_nx_s = bit_cnt_r + BIT_ONE;
        end
      end
      ST_PARITY: begin
        state_nx_s = ST_STOP;
      end
      ST_STOP: begin
        if (accept_s) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        bit_cnt_nx_s = BIT_ZERO;
      end
    endcase
  end

  // Line source for the coming cycle follows the next state.
  assign mux_sel_nx_s = mux_sel_of(state_nx_s);

  // The data bit is addressed with the next counter value so the registered
  // line carries frame[bit_cnt] in the same cycle that bit_cnt holds it;
  // par_bit is captured on the edge that enters the parity state.
  uart_tx_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_mux (
    .mux_sel (mux_sel_nx_s),
    .frame   (frame_r),
    .bit_idx (bit_cnt_nx_s),
    .par_bit (par_bit),
    .line_s  (line_nx_s)
  );

  // FSM state, frame capture and registered line/status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= BIT_ZERO;
      frame_r   <= {DATA_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      mux_sel   <= MUX_STOP;
    end else begin
      state_r   <= state_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      if (accept_s) begin
        frame_r  <= P_DATA;
        par_en_r <= PAR_EN;
      end else begin
        frame_r  <= frame_r;
        par_en_r <= par_en_r;
      end
      TX_OUT  <= line_nx_s;
      Busy    <= busy_of(state_nx_s);
      mux_sel <= mux_sel_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: hand-computed line patterns for an
// 8-bit instance (with an odd-parity model on the parity port) and a
// 5-bit instance.
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       RST;

  logic [7:0] P_DATA;
  logic       DATA_Valid;
  logic       PAR_EN;
  logic       par_bit = 1'b0;
  logic [7:0] par_data;
  logic       par_valid;
  logic [1:0] mux_sel;
  logic       TX_OUT;
  logic       Busy;

  logic [4:0] p_data5;
  logic       data_valid5;
  logic       par_en5;
  logic       par_bit5;
  logic [4:0] par_data5;
  logic       par_valid5;
  logic [1:0] mux_sel5;
  logic       tx_out5;
  logic       busy5;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int pv_total  = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_Valid (DATA_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .par_data   (par_data),
    .par_valid  (par_valid),
    .mux_sel    (mux_sel),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) u_dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (p_data5),
    .DATA_Valid (data_valid5),
    .PAR_EN     (par_en5),
    .par_bit    (par_bit5),
    .par_data   (par_data5),
    .par_valid  (par_valid5),
    .mux_sel    (mux_sel5),
    .TX_OUT     (tx_out5),
    .Busy       (busy5)
  );

  // Clock: 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Odd-parity unit model and par_valid pulse counter, both mid-cycle.
  always @(negedge CLK) begin
    if (par_valid === 1'b1) begin
      par_bit  = ~^par_data;
      pv_total = pv_total + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Accept one frame in the current (idle) cycle and check the line for n
  // cycles. exp_tx lists the line levels with cycle 1 as the leftmost bit.
  // Optionally drive DATA_Valid again at cycle inj_cyc and check par_valid.
  task automatic run_seq(input string tag, input logic [31:0] exp_tx, input int n,
                         input logic [7:0] d, input logic pen,
                         input int inj_cyc, input logic [7:0] inj_d, input logic inj_pv,
                         input int sel_cyc, input logic [1:0] sel_exp, input int exp_pv);
    int pv_base;
    pv_base    = pv_total;
    P_DATA     = d;
    PAR_EN     = pen;
    DATA_Valid = 1'b1;
    #1;
    check_val($sformatf("%s/pv_acc", tag), par_valid, 1);
    check_val($sformatf("%s/pdata", tag), par_data, d);
    tick();
    DATA_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    for (int c = 1; c <= n; c++) begin
      check_val($sformatf("%s/tx%0d", tag, c), TX_OUT, exp_tx[n-c]);
      check_val($sformatf("%s/busy%0d", tag, c), Busy, 1);
      if (c == sel_cyc) begin
        check_val($sformatf("%s/sel%0d", tag, c), mux_sel, sel_exp);
      end
      if (c == inj_cyc) begin
        DATA_Valid = 1'b1;
        P_DATA     = inj_d;
        #1;
        check_val($sformatf("%s/pv_inj", tag), par_valid, inj_pv);
        check_val($sformatf("%s/pdata_inj", tag), par_data, inj_d);
      end
      tick();
      DATA_Valid = 1'b0;
      P_DATA     = 8'h00;
    end
    check_val($sformatf("%s/busy_end", tag), Busy, 0);
    check_val($sformatf("%s/tx_end", tag), TX_OUT, 1);
    check_val($sformatf("%s/sel_end", tag), mux_sel, 2'b01);
    check_val($sformatf("%s/pv_count", tag), pv_total - pv_base, exp_pv);
  endtask

  initial begin
    logic [3:0] exp_abort;
    logic [6:0] exp5;

    RST         = 1'b1;
    DATA_Valid  = 1'b1;
    P_DATA      = 8'hFF;
    PAR_EN      = 1'b0;
    p_data5     = 5'h00;
    data_valid5 = 1'b0;
    par_en5     = 1'b0;
    par_bit5    = 1'b0;

    // Reset state, with DATA_Valid held high to show par_valid is blocked.
    tick();
    tick();
    check_val("rst/pv", par_valid, 0);
    check_val("rst/tx", TX_OUT, 1);
    check_val("rst/busy", Busy, 0);
    check_val("rst/sel", mux_sel, 2'b01);
    check_val("rst/tx5", tx_out5, 1);
    check_val("rst/busy5", busy5, 0);
    DATA_Valid = 1'b0;
    P_DATA     = 8'h00;
    RST        = 1'b0;
    tick();
    check_val("idle/tx", TX_OUT, 1);
    check_val("idle/busy", Busy, 0);

    // 0xA5 without parity: 10-cycle frame.
    run_seq("a5_np", 32'b0101001011, 10, 8'hA5, 1'b0, 0, 8'h00, 1'b0, 1, 2'b00, 1);

    // 0xA5 with parity; odd parity of 0xA5 is 1.
    run_seq("a5_par", 32'b01010010111, 11, 8'hA5, 1'b1, 0, 8'h00, 1'b0, 10, 2'b11, 1);

    // 0x3C then 0xFF accepted in the stop cycle: no idle gap.
    run_seq("b2b", 32'b0001111001_0111111111, 20, 8'h3C, 1'b0, 10, 8'hFF, 1'b1, 11, 2'b00, 2);

    // 0x5A with a stray 0x00 strobe during data bits: ignored.
    run_seq("ign", 32'b0010110101, 10, 8'h5A, 1'b0, 4, 8'h00, 1'b0, 5, 2'b10, 1);

    // Reset in the 4th data cycle of an 0xA5 frame aborts it.
    exp_abort  = 4'b1010;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    DATA_Valid = 1'b1;
    tick();
    DATA_Valid = 1'b0;
    P_DATA     = 8'h00;
    check_val("abort/tx1", TX_OUT, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check_val($sformatf("abort/tx%0d", c), TX_OUT, exp_abort[5-c]);
    end
    check_val("abort/busy5", Busy, 1);
    RST = 1'b1;
    tick();
    check_val("abort/tx6", TX_OUT, 1);
    check_val("abort/busy6", Busy, 0);
    check_val("abort/sel6", mux_sel, 2'b01);
    RST = 1'b0;
    tick();
    check_val("abort/tx7", TX_OUT, 1);
    check_val("abort/busy7", Busy, 0);
    run_seq("post_rst", 32'b0110000111, 10, 8'hC3, 1'b0, 0, 8'h00, 1'b0, 10, 2'b01, 1);

    // 5-bit instance: 0x15 without parity is a 7-cycle frame.
    exp5        = 7'b0101011;
    p_data5     = 5'h15;
    data_valid5 = 1'b1;
    #1;
    check_val("w5/pv", par_valid5, 1);
    check_val("w5/pdata", par_data5, 5'h15);
    tick();
    data_valid5 = 1'b0;
    p_data5     = 5'h00;
    check_val("w5/sel1", mux_sel5, 2'b00);
    for (int c = 1; c <= 7; c++) begin
      check_val($sformatf("w5/tx%0d", c), tx_out5, exp5[7-c]);
      check_val($sformatf("w5/busy%0d", c), busy5, 1);
      tick();
    end
    check_val("w5/busy_end", busy5, 0);
    check_val("w5/tx_end", tx_out5, 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
